// File: rtl/ucode_store_decoder_if.sv
// ----------------------------------------------------------------------------
// ucode_store_decoder_if
//   Bus bundle between the microcode store/decoder and its environment
//   (loader, job issuer, microcode sequencer, datapath).
//
//   Loader  : ld_valid/ld_ready handshake, ld_addr, ld_data
//   Job     : cmd_valid/cmd_ready handshake, cmd_entry
//   Sequencer: start_pos, upc_start, upc, upc_up, upc_st, done, loop_0..3
//   Datapath: ctrl_valid, ctrl_out
//   Status  : busy (and parity_err when UCODE_PARITY_EN is defined)
//
//   Modports: slave  = the decoder itself
//             master = the environment driving it
// ----------------------------------------------------------------------------
interface ucode_store_decoder_if #(
    parameter int UINST_ADDR_WIDTH = 8,
    parameter int UINST_WIDTH      = 32,
    parameter int CTRL_WIDTH       = 23
);
    logic                        ld_valid;
    logic                        ld_ready;
    logic [UINST_ADDR_WIDTH-1:0] ld_addr;
    logic [UINST_WIDTH-1:0]      ld_data;

    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [UINST_ADDR_WIDTH-1:0] cmd_entry;

    logic                        start_pos;
    logic [UINST_ADDR_WIDTH-1:0] upc_start;
    logic [UINST_ADDR_WIDTH-1:0] upc;
    logic [2:0]                  upc_up;
    logic [2:0]                  upc_st;
    logic                        done;
    logic [10:0]                 loop_0;
    logic [10:0]                 loop_1;
    logic [10:0]                 loop_2;
    logic [10:0]                 loop_3;

    logic                        ctrl_valid;
    logic [CTRL_WIDTH-1:0]       ctrl_out;
    logic                        busy;
`ifdef UCODE_PARITY_EN
    logic                        parity_err;
`endif

    modport slave (
        input  ld_valid, ld_addr, ld_data, cmd_valid, cmd_entry, upc,
        output ld_ready, cmd_ready, start_pos, upc_start, upc_up, upc_st, done,
               loop_0, loop_1, loop_2, loop_3, ctrl_valid, ctrl_out, busy
`ifdef UCODE_PARITY_EN
             , parity_err
`endif
    );

    modport master (
        output ld_valid, ld_addr, ld_data, cmd_valid, cmd_entry, upc,
        input  ld_ready, cmd_ready, start_pos, upc_start, upc_up, upc_st, done,
               loop_0, loop_1, loop_2, loop_3, ctrl_valid, ctrl_out, busy
`ifdef UCODE_PARITY_EN
             , parity_err
`endif
    );
endinterface

// File: rtl/ucode_store_decoder.sv
// ----------------------------------------------------------------------------
// ucode_store_decoder
//   Loadable microcode store plus instruction decoder feeding the microcode
//   sequencer. The word at the sequencer's upc is read combinationally and
//   decoded into loop-start / loop-back / done controls for the sequencer,
//   loop iteration counts, and a registered datapath control word.
//
//   Ports:
//     clk   - clock
//     rstn  - asynchronous active-low reset
//     bus   - ucode_store_decoder_if.slave (load port, job port, sequencer
//             controls, datapath control word, busy)
//
//   Instruction word: [31:29] op (000 EXEC, 001 SETLOOP, 010 END, others act
//   as EXEC without ctrl_valid), [28:26] upc_up, [25:23] upc_st,
//   EXEC [22:0] ctrl, SETLOOP [22:21] loop index and [10:0] count.
//
//   Optional feature macro: UCODE_PARITY_EN
//     Stores an even-parity bit with every word; a mismatch seen in RUN ends
//     the job (done=1, no loop controls, no ctrl_valid) and sets the sticky
//     parity_err, which clears on reset or the next accepted job.
//
//   CTRL_WIDTH must equal UINST_WIDTH-9.
// ----------------------------------------------------------------------------
module ucode_store_decoder #(
    parameter int UINST_ADDR_WIDTH = 8,
    parameter int UINST_WIDTH      = 32,
    parameter int CTRL_WIDTH       = 23
) (
    input  logic                 clk,
    input  logic                 rstn,
    ucode_store_decoder_if.slave bus
);
    localparam int DEPTH = 1 << UINST_ADDR_WIDTH;
`ifdef UCODE_PARITY_EN
    localparam int MEM_WIDTH = UINST_WIDTH + 1;
`else
    localparam int MEM_WIDTH = UINST_WIDTH;
`endif

    localparam logic [2:0] OP_EXEC    = 3'b000;
    localparam logic [2:0] OP_SETLOOP = 3'b001;
    localparam logic [2:0] OP_END     = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [MEM_WIDTH-1:0]        mem [DEPTH];
    logic [MEM_WIDTH-1:0]        rd_word;
    logic [UINST_WIDTH-1:0]      uinst;
    logic [2:0]                  op;
    logic [2:0]                  fld_up;
    logic [2:0]                  fld_st;
    logic [1:0]                  loop_idx;
    logic [10:0]                 loop_cnt;

    logic                        accept;
    logic                        ld_fire;
    logic                        exec_fire;
    logic                        setloop_fire;
    logic [2:0]                  upc_up_c;
    logic [2:0]                  upc_st_c;
    logic                        done_c;

    logic                        start_pos_r;
    logic [UINST_ADDR_WIDTH-1:0] upc_start_r;
    logic                        ctrl_valid_r;
    logic [CTRL_WIDTH-1:0]       ctrl_out_r;
    logic [10:0]                 loop_r [4];

`ifdef UCODE_PARITY_EN
    logic                        par_bad;
    logic                        parity_err_r;
`endif

    // Both handshakes are only honoured while idle.
    assign accept  = (state == IDLE) && bus.cmd_valid;
    assign ld_fire = (state == IDLE) && bus.ld_valid;

    // ------------------------------------------------------------------
    // Microcode store
    // ------------------------------------------------------------------
    // NOTE: the store array has no reset branch on purpose -- its contents
    // must survive rstn, and a reset on every word would also prevent the
    // array from mapping onto plain storage.
    always_ff @(posedge clk) begin
        if (ld_fire) begin
`ifdef UCODE_PARITY_EN
            mem[bus.ld_addr] <= {^bus.ld_data, bus.ld_data};
`else
            mem[bus.ld_addr] <= bus.ld_data;
`endif
        end
    end

    // Zero-latency read: the sequencer consumes upc_up in the same cycle.
    assign rd_word  = mem[bus.upc];
    assign uinst    = rd_word[UINST_WIDTH-1:0];
    assign op       = uinst[UINST_WIDTH-1 -: 3];
    assign fld_up   = uinst[UINST_WIDTH-4 -: 3];
    assign fld_st   = uinst[UINST_WIDTH-7 -: 3];
    assign loop_idx = uinst[CTRL_WIDTH-1 -: 2];
    assign loop_cnt = uinst[10:0];

`ifdef UCODE_PARITY_EN
    // Even parity over data plus stored parity bit must be zero.
    assign par_bad  = ^rd_word;
`endif

    // ------------------------------------------------------------------
    // Next state and combinational decode
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt    = state;
        upc_up_c     = 3'b000;
        upc_st_c     = 3'b000;
        done_c       = 1'b0;
        exec_fire    = 1'b0;
        setloop_fire = 1'b0;

        case (state)
            IDLE: begin
                if (bus.cmd_valid) state_nxt = START;
            end
            START: begin
                state_nxt = RUN;
            end
            RUN: begin
                upc_up_c     = fld_up;
                upc_st_c     = fld_st;
                done_c       = (op == OP_END);
                exec_fire    = (op == OP_EXEC);
                setloop_fire = (op == OP_SETLOOP);
`ifdef UCODE_PARITY_EN
                // A corrupted word must not steer the sequencer or the
                // datapath; end the job instead.
                if (par_bad) begin
                    upc_up_c     = 3'b000;
                    upc_st_c     = 3'b000;
                    done_c       = 1'b1;
                    exec_fire    = 1'b0;
                    setloop_fire = 1'b0;
                end
`endif
                if (done_c) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            start_pos_r  <= 1'b0;
            upc_start_r  <= '0;
            ctrl_valid_r <= 1'b0;
            ctrl_out_r   <= '0;
            for (int i = 0; i < 4; i++) loop_r[i] <= '0;
`ifdef UCODE_PARITY_EN
            parity_err_r <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            // High exactly during the START cycle.
            start_pos_r  <= accept;
            if (accept) upc_start_r <= bus.cmd_entry;

            ctrl_valid_r <= exec_fire;
            if (exec_fire) ctrl_out_r <= uinst[CTRL_WIDTH-1:0];

            // New count becomes visible from the following word on, so a
            // upc_st in the same SETLOOP word still sees the old count.
            if (setloop_fire) loop_r[loop_idx] <= loop_cnt;
`ifdef UCODE_PARITY_EN
            if (accept)
                parity_err_r <= 1'b0;
            else if ((state == RUN) && par_bad)
                parity_err_r <= 1'b1;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign bus.ld_ready   = (state == IDLE);
    assign bus.cmd_ready  = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.start_pos  = start_pos_r;
    assign bus.upc_start  = upc_start_r;
    assign bus.upc_up     = upc_up_c;
    assign bus.upc_st     = upc_st_c;
    assign bus.done       = done_c;
    assign bus.loop_0     = loop_r[0];
    assign bus.loop_1     = loop_r[1];
    assign bus.loop_2     = loop_r[2];
    assign bus.loop_3     = loop_r[3];
    assign bus.ctrl_valid = ctrl_valid_r;
    assign bus.ctrl_out   = ctrl_out_r;
`ifdef UCODE_PARITY_EN
    assign bus.parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_ucode_store_decoder.sv
// ----------------------------------------------------------------------------
// tb_ucode_store_decoder
//   Scoreboard bench for ucode_store_decoder. A small sequencer stub closes
//   the upc loop; a program-level reference model predicts the executed
//   address trace, the datapath control words and the final loop counts.
//   A monitor pops and compares on every falling clock edge.
// ----------------------------------------------------------------------------
module tb_ucode_store_decoder;
    localparam int AW = 8;
    localparam int W  = 32;
    localparam int CW = 23;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    ucode_store_decoder_if #(.UINST_ADDR_WIDTH(AW), .UINST_WIDTH(W), .CTRL_WIDTH(CW)) bus ();

    ucode_store_decoder #(.UINST_ADDR_WIDTH(AW), .UINST_WIDTH(W), .CTRL_WIDTH(CW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [W-1:0]  img [256];
    int            model_loop [4];
    logic [CW-1:0] exp_ctrl [$];
    logic [AW-1:0] exp_upc [$];

    logic [CW-1:0] last_ctrl;
    bit            expect_start;
    bit            prev_done;
    logic [AW-1:0] entry_seen;
    bit            bad_en;
    logic [AW-1:0] bad_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [10:0] loop_val(input logic [1:0] idx);
        case (idx)
            2'd0:    return bus.loop_0;
            2'd1:    return bus.loop_1;
            2'd2:    return bus.loop_2;
            default: return bus.loop_3;
        endcase
    endfunction

    // Reference model: walks the program as the sequencer would and records
    // what the decoder must present. Loop starts capture the count held
    // before the current word's own SETLOOP takes effect.
    function automatic void run_model(input logic [AW-1:0] entry, input bit stop_bad,
                                      input logic [AW-1:0] bad);
        logic [AW-1:0] pc;
        logic [AW-1:0] ls [4];
        int            cnt [4];
        logic [W-1:0]  w;
        for (int i = 0; i < 4; i++) begin
            ls[i]  = '0;
            cnt[i] = 0;
        end
        pc = entry;
        for (int step = 0; step < 4000; step++) begin
            w = img[pc];
            exp_upc.push_back(pc);
            if (stop_bad && pc == bad) break;
            if (w[31:29] == 3'd2) break;
            if (w[31:29] == 3'd0) exp_ctrl.push_back(w[22:0]);
            if (w[25]) begin
                ls[w[24:23]]  = pc + 8'd1;
                cnt[w[24:23]] = model_loop[w[24:23]];
            end
            if (w[31:29] == 3'd1) model_loop[w[22:21]] = int'(w[10:0]);
            if (w[28] && cnt[w[27:26]] > 1) begin
                cnt[w[27:26]] = cnt[w[27:26]] - 1;
                pc = ls[w[27:26]];
            end else begin
                pc = pc + 8'd1;
            end
        end
    endfunction

    // Sequencer stub: loads upc on start_pos, then follows loop controls.
    initial begin : sequencer
        logic [AW-1:0] nxt;
        logic [AW-1:0] s_ls [4];
        int            s_cnt [4];
        bus.upc = '0;
        for (int i = 0; i < 4; i++) begin
            s_ls[i]  = '0;
            s_cnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            nxt = bus.upc;
            if (!rstn || bus.start_pos) begin
                for (int i = 0; i < 4; i++) begin
                    s_ls[i]  = '0;
                    s_cnt[i] = 0;
                end
                if (rstn) nxt = bus.upc_start;
            end else if (bus.busy && !bus.done) begin
                if (bus.upc_st[2]) begin
                    s_ls[bus.upc_st[1:0]]  = bus.upc + 8'd1;
                    s_cnt[bus.upc_st[1:0]] = int'(loop_val(bus.upc_st[1:0]));
                end
                if (bus.upc_up[2] && s_cnt[bus.upc_up[1:0]] > 1) begin
                    s_cnt[bus.upc_up[1:0]] = s_cnt[bus.upc_up[1:0]] - 1;
                    nxt = s_ls[bus.upc_up[1:0]];
                end else begin
                    nxt = bus.upc + 8'd1;
                end
            end
            @(posedge clk);
            #1 bus.upc = nxt;
        end
    end

    // Monitor / scoreboard.
    initial begin : monitor
        logic [AW-1:0] eu;
        logic [W-1:0]  w;
        logic [2:0]    e_up;
        logic [2:0]    e_st;
        logic          e_done;
        last_ctrl    = '0;
        expect_start = 1'b0;
        prev_done    = 1'b0;
        entry_seen   = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                expect_start = 1'b0;
                prev_done    = 1'b0;
                last_ctrl    = '0;
                continue;
            end
            check("start_pos", 32'(bus.start_pos), 32'(expect_start));
            if (expect_start) check("upc_start", 32'(bus.upc_start), 32'(entry_seen));
            if (prev_done) check("busy_after_done", 32'(bus.busy), 32'd0);
            check("cmd_ready", 32'(bus.cmd_ready), 32'(!bus.busy));
            check("ld_ready", 32'(bus.ld_ready), 32'(!bus.busy));

            if (bus.busy && !bus.start_pos) begin
                if (exp_upc.size() == 0) begin
                    fail_now("upc_trace_extra");
                end else begin
                    eu = exp_upc.pop_front();
                    check("upc_trace", 32'(bus.upc), 32'(eu));
                end
                w      = img[bus.upc];
                e_up   = w[28:26];
                e_st   = w[25:23];
                e_done = (w[31:29] == 3'd2);
                if (bad_en && bus.upc == bad_addr) begin
                    e_up   = 3'b000;
                    e_st   = 3'b000;
                    e_done = 1'b1;
                end
                check("upc_up_run", 32'(bus.upc_up), 32'(e_up));
                check("upc_st_run", 32'(bus.upc_st), 32'(e_st));
                check("done_run", 32'(bus.done), 32'(e_done));
                prev_done = bus.done;
            end else begin
                check("upc_up_idle", 32'(bus.upc_up), 32'd0);
                check("upc_st_idle", 32'(bus.upc_st), 32'd0);
                check("done_idle", 32'(bus.done), 32'd0);
                prev_done = 1'b0;
            end

            if (bus.ctrl_valid) begin
                if (exp_ctrl.size() == 0) begin
                    fail_now("ctrl_valid_extra");
                end else begin
                    last_ctrl = exp_ctrl.pop_front();
                    check("ctrl_out", 32'(bus.ctrl_out), 32'(last_ctrl));
                end
            end else begin
                check("ctrl_out_hold", 32'(bus.ctrl_out), 32'(last_ctrl));
            end

            expect_start = bus.cmd_valid && bus.cmd_ready;
            if (expect_start) entry_seen = bus.cmd_entry;
        end
    end

    // Driver helpers; all start and end at posedge+1.
    task automatic load_word(input logic [AW-1:0] a, input logic [W-1:0] d);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        @(posedge clk);
        #1 bus.ld_valid = 1'b0;
        img[a] = d;
    endtask

    task automatic start_cmd(input logic [AW-1:0] entry);
        bit ok;
        ok = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_entry = entry;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("cmd_accept_timeout");
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("job_timeout");
    endtask

    task automatic end_checks();
        check("ctrl_queue_drained", 32'(exp_ctrl.size()), 32'd0);
        check("upc_queue_drained", 32'(exp_upc.size()), 32'd0);
        check("loop_0", 32'(bus.loop_0), 32'(model_loop[0]));
        check("loop_1", 32'(bus.loop_1), 32'(model_loop[1]));
        check("loop_2", 32'(bus.loop_2), 32'(model_loop[2]));
        check("loop_3", 32'(bus.loop_3), 32'(model_loop[3]));
        exp_ctrl.delete();
        exp_upc.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input logic [AW-1:0] entry);
        run_model(entry, 1'b0, '0);
        start_cmd(entry);
        wait_idle();
        end_checks();
    endtask

    task automatic check_reset_state();
        check("rst_start_pos", 32'(bus.start_pos), 32'd0);
        check("rst_upc_start", 32'(bus.upc_start), 32'd0);
        check("rst_ctrl_valid", 32'(bus.ctrl_valid), 32'd0);
        check("rst_ctrl_out", 32'(bus.ctrl_out), 32'd0);
        check("rst_loops", 32'({bus.loop_0, bus.loop_1}), 32'd0);
        check("rst_loops_hi", 32'({bus.loop_2, bus.loop_3}), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_decode", 32'({bus.upc_up, bus.upc_st, bus.done}), 32'd0);
`ifdef UCODE_PARITY_EN
        check("rst_parity_err", 32'(bus.parity_err), 32'd0);
`endif
    endtask

    task automatic load_loop_prog();
        load_word(8'd0, {3'd1, 3'd0, 3'd0, 2'd1, 10'd0, 11'd3});
        load_word(8'd1, {3'd0, 3'd0, 3'b101, 23'h0000aa});
        load_word(8'd2, {3'd0, 3'b101, 3'd0, 23'h0000bb});
        load_word(8'd3, {3'd2, 3'd0, 3'd0, 23'h0});
    endtask

    task automatic gen_and_load(input logic [AW-1:0] entry, input int n);
        int           k;
        int           m;
        int           j;
        logic [2:0]   up;
        logic [2:0]   st;
        logic [W-1:0] w;
        k = $urandom_range(0, n - 3);
        m = $urandom_range(k + 1, n - 2);
        j = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) begin
            up = 3'b000;
            st = 3'b000;
            if (i == n - 1) begin
                w = {3'd2, 3'($urandom), 3'($urandom), 23'($urandom)};
            end else begin
                if (i == k) st = {1'b1, 2'(j)};
                if (i == m) up = {1'b1, 2'(j)};
                case ($urandom_range(0, 5))
                    0, 1, 2: w = {3'd0, up, st, 23'($urandom)};
                    3:       w = {3'd1, up, st, 2'($urandom), 10'd0, 11'($urandom_range(0, 5))};
                    default: w = {3'($urandom_range(3, 7)), up, st, 23'($urandom)};
                endcase
            end
            load_word(entry + 8'(i), w);
        end
    endtask

    // Watchdog: the run must never hang.
    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        bit ok;
        bus.ld_valid  = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_entry = '0;
        bad_en        = 1'b0;
        bad_addr      = '0;
        for (int i = 0; i < 256; i++) img[i] = '0;
        for (int i = 0; i < 4; i++) model_loop[i] = 0;

        #1 rstn = 1'b0;
        #1 check_reset_state();
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Basic EXEC then END from entry 4.
        load_word(8'd4, {3'd0, 3'd0, 3'd0, 23'h001234});
        load_word(8'd5, {3'd2, 3'd0, 3'd0, 23'h0});
        run_job(8'd4);

        // SETLOOP then a three-pass loop over word 2.
        load_loop_prog();
        run_job(8'd0);

        // Load attempts while running must be ignored.
        run_model(8'd0, 1'b0, '0);
        start_cmd(8'd0);
        @(posedge clk);
        #1;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 8'd2;
        bus.ld_data  = 32'hdead_beef;
        repeat (3) @(posedge clk);
        #1 bus.ld_valid = 1'b0;
        wait_idle();
        end_checks();
        run_job(8'd0);

        // Command held during RUN is taken right after the job ends.
        run_model(8'd0, 1'b0, '0);
        run_model(8'd0, 1'b0, '0);
        start_cmd(8'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_entry = 8'd0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("held_cmd_timeout");
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        wait_idle();
        end_checks();

        // Random programs, loop counts carried across jobs.
        repeat (16) begin
            logic [AW-1:0] e;
            e = 8'($urandom);
            gen_and_load(e, $urandom_range(3, 10));
            run_job(e);
        end

        // Reset in the middle of RUN, then identical re-run.
        load_loop_prog();
        run_model(8'd0, 1'b0, '0);
        start_cmd(8'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rstn = 1'b0;
        exp_ctrl.delete();
        exp_upc.delete();
        for (int i = 0; i < 4; i++) model_loop[i] = 0;
        #1 check_reset_state();
        @(posedge clk);
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;
        run_job(8'd0);

`ifdef UCODE_PARITY_EN
        // Corrupt one stored bit behind the decoder's back.
        load_word(8'h40, {3'd0, 3'd0, 3'd0, 23'h000111});
        load_word(8'h41, {3'd0, 3'd0, 3'd0, 23'h000222});
        load_word(8'h42, {3'd0, 3'd0, 3'd0, 23'h000333});
        load_word(8'h43, {3'd2, 3'd0, 3'd0, 23'h0});
        dut.mem[8'h41][5] = ~dut.mem[8'h41][5];
        bad_addr = 8'h41;
        bad_en   = 1'b1;
        run_model(8'h40, 1'b1, 8'h41);
        start_cmd(8'h40);
        wait_idle();
        check("parity_err_set", 32'(bus.parity_err), 32'd1);
        end_checks();
        bad_en = 1'b0;
        load_word(8'h41, img[8'h41]);
        check("parity_err_sticky", 32'(bus.parity_err), 32'd1);
        run_model(8'h40, 1'b0, '0);
        start_cmd(8'h40);
        check("parity_err_clear", 32'(bus.parity_err), 32'd0);
        wait_idle();
        end_checks();
`endif

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
